// File: rtl/aes_ks_pkg.sv
// Shared types, sizes, round constants and word helpers for the AES-128 key-expansion sequencer.
package aes_ks_pkg;

    localparam int unsigned NUM_RK   = 11;
    localparam int unsigned LAST_IDX = NUM_RK - 1;
    localparam int unsigned RK_W     = 128;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned NUM_RCON = 10;

    // Symbolic state names; the sequencer register uses the matching 1-bit constants.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    localparam logic [7:0] RCON [0:NUM_RCON-1] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Byte-rotate a word left by one: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[WORD_W-9:0], w[WORD_W-1 -: 8]};
    endfunction

    // Bytewise GF(2) addition of two words.
    function automatic logic [WORD_W-1:0] xor_words(input logic [WORD_W-1:0] a,
                                                    input logic [WORD_W-1:0] b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/aes_key_expand_seq_sbox.sv
// aes_sbox: combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // Table lookup, rows grouped by input high nibble.
    always_comb begin
        data_o = 8'h00;
        case (data_i)
            8'h00: data_o = 8'h63; 8'h01: data_o = 8'h7c; 8'h02: data_o = 8'h77; 8'h03: data_o = 8'h7b; 8'h04: data_o = 8'hf2; 8'h05: data_o = 8'h6b; 8'h06: data_o = 8'h6f; 8'h07: data_o = 8'hc5;
            8'h08: data_o = 8'h30; 8'h09: data_o = 8'h01; 8'h0a: data_o = 8'h67; 8'h0b: data_o = 8'h2b; 8'h0c: data_o = 8'hfe; 8'h0d: data_o = 8'hd7; 8'h0e: data_o = 8'hab; 8'h0f: data_o = 8'h76;
            8'h10: data_o = 8'hca; 8'h11: data_o = 8'h82; 8'h12: data_o = 8'hc9; 8'h13: data_o = 8'h7d; 8'h14: data_o = 8'hfa; 8'h15: data_o = 8'h59; 8'h16: data_o = 8'h47; 8'h17: data_o = 8'hf0;
            8'h18: data_o = 8'had; 8'h19: data_o = 8'hd4; 8'h1a: data_o = 8'ha2; 8'h1b: data_o = 8'haf; 8'h1c: data_o = 8'h9c; 8'h1d: data_o = 8'ha4; 8'h1e: data_o = 8'h72; 8'h1f: data_o = 8'hc0;
            8'h20: data_o = 8'hb7; 8'h21: data_o = 8'hfd; 8'h22: data_o = 8'h93; 8'h23: data_o = 8'h26; 8'h24: data_o = 8'h36; 8'h25: data_o = 8'h3f; 8'h26: data_o = 8'hf7; 8'h27: data_o = 8'hcc;
            8'h28: data_o = 8'h34; 8'h29: data_o = 8'ha5; 8'h2a: data_o = 8'he5; 8'h2b: data_o = 8'hf1; 8'h2c: data_o = 8'h71; 8'h2d: data_o = 8'hd8; 8'h2e: data_o = 8'h31; 8'h2f: data_o = 8'h15;
            8'h30: data_o = 8'h04; 8'h31: data_o = 8'hc7; 8'h32: data_o = 8'h23; 8'h33: data_o = 8'hc3; 8'h34: data_o = 8'h18; 8'h35: data_o = 8'h96; 8'h36: data_o = 8'h05; 8'h37: data_o = 8'h9a;
            8'h38: data_o = 8'h07; 8'h39: data_o = 8'h12; 8'h3a: data_o = 8'h80; 8'h3b: data_o = 8'he2; 8'h3c: data_o = 8'heb; 8'h3d: data_o = 8'h27; 8'h3e: data_o = 8'hb2; 8'h3f: data_o = 8'h75;
            8'h40: data_o = 8'h09; 8'h41: data_o = 8'h83; 8'h42: data_o = 8'h2c; 8'h43: data_o = 8'h1a; 8'h44: data_o = 8'h1b; 8'h45: data_o = 8'h6e; 8'h46: data_o = 8'h5a; 8'h47: data_o = 8'ha0;
            8'h48: data_o = 8'h52; 8'h49: data_o = 8'h3b; 8'h4a: data_o = 8'hd6; 8'h4b: data_o = 8'hb3; 8'h4c: data_o = 8'h29; 8'h4d: data_o = 8'he3; 8'h4e: data_o = 8'h2f; 8'h4f: data_o = 8'h84;
            8'h50: data_o = 8'h53; 8'h51: data_o = 8'hd1; 8'h52: data_o = 8'h00; 8'h53: data_o = 8'hed; 8'h54: data_o = 8'h20; 8'h55: data_o = 8'hfc; 8'h56: data_o = 8'hb1; 8'h57: data_o = 8'h5b;
            8'h58: data_o = 8'h6a; 8'h59: data_o = 8'hcb; 8'h5a: data_o = 8'hbe; 8'h5b: data_o = 8'h39; 8'h5c: data_o = 8'h4a; 8'h5d: data_o = 8'h4c; 8'h5e: data_o = 8'h58; 8'h5f: data_o = 8'hcf;
            8'h60: data_o = 8'hd0; 8'h61: data_o = 8'hef; 8'h62: data_o = 8'haa; 8'h63: data_o = 8'hfb; 8'h64: data_o = 8'h43; 8'h65: data_o = 8'h4d; 8'h66: data_o = 8'h33; 8'h67: data_o = 8'h85;
            8'h68: data_o = 8'h45; 8'h69: data_o = 8'hf9; 8'h6a: data_o = 8'h02; 8'h6b: data_o = 8'h7f; 8'h6c: data_o = 8'h50; 8'h6d: data_o = 8'h3c; 8'h6e: data_o = 8'h9f; 8'h6f: data_o = 8'ha8;
            8'h70: data_o = 8'h51; 8'h71: data_o = 8'ha3; 8'h72: data_o = 8'h40; 8'h73: data_o = 8'h8f; 8'h74: data_o = 8'h92; 8'h75: data_o = 8'h9d; 8'h76: data_o = 8'h38; 8'h77: data_o = 8'hf5;
            8'h78: data_o = 8'hbc; 8'h79: data_o = 8'hb6; 8'h7a: data_o = 8'hda; 8'h7b: data_o = 8'h21; 8'h7c: data_o = 8'h10; 8'h7d: data_o = 8'hff; 8'h7e: data_o = 8'hf3; 8'h7f: data_o = 8'hd2;
            8'h80: data_o = 8'hcd; 8'h81: data_o = 8'h0c; 8'h82: data_o = 8'h13; 8'h83: data_o = 8'hec; 8'h84: data_o = 8'h5f; 8'h85: data_o = 8'h97; 8'h86: data_o = 8'h44; 8'h87: data_o = 8'h17;
            8'h88: data_o = 8'hc4; 8'h89: data_o = 8'ha7; 8'h8a: data_o = 8'h7e; 8'h8b: data_o = 8'h3d; 8'h8c: data_o = 8'h64; 8'h8d: data_o = 8'h5d; 8'h8e: data_o = 8'h19; 8'h8f: data_o = 8'h73;
            8'h90: data_o = 8'h60; 8'h91: data_o = 8'h81; 8'h92: data_o = 8'h4f; 8'h93: data_o = 8'hdc; 8'h94: data_o = 8'h22; 8'h95: data_o = 8'h2a; 8'h96: data_o = 8'h90; 8'h97: data_o = 8'h88;
            8'h98: data_o = 8'h46; 8'h99: data_o = 8'hee; 8'h9a: data_o = 8'hb8; 8'h9b: data_o = 8'h14; 8'h9c: data_o = 8'hde; 8'h9d: data_o = 8'h5e; 8'h9e: data_o = 8'h0b; 8'h9f: data_o = 8'hdb;
            8'ha0: data_o = 8'he0; 8'ha1: data_o = 8'h32; 8'ha2: data_o = 8'h3a; 8'ha3: data_o = 8'h0a; 8'ha4: data_o = 8'h49; 8'ha5: data_o = 8'h06; 8'ha6: data_o = 8'h24; 8'ha7: data_o = 8'h5c;
            8'ha8: data_o = 8'hc2; 8'ha9: data_o = 8'hd3; 8'haa: data_o = 8'hac; 8'hab: data_o = 8'h62; 8'hac: data_o = 8'h91; 8'had: data_o = 8'h95; 8'hae: data_o = 8'he4; 8'haf: data_o = 8'h79;
            8'hb0: data_o = 8'he7; 8'hb1: data_o = 8'hc8; 8'hb2: data_o = 8'h37; 8'hb3: data_o = 8'h6d; 8'hb4: data_o = 8'h8d; 8'hb5: data_o = 8'hd5; 8'hb6: data_o = 8'h4e; 8'hb7: data_o = 8'ha9;
            8'hb8: data_o = 8'h6c; 8'hb9: data_o = 8'h56; 8'hba: data_o = 8'hf4; 8'hbb: data_o = 8'hea; 8'hbc: data_o = 8'h65; 8'hbd: data_o = 8'h7a; 8'hbe: data_o = 8'hae; 8'hbf: data_o = 8'h08;
            8'hc0: data_o = 8'hba; 8'hc1: data_o = 8'h78; 8'hc2: data_o = 8'h25; 8'hc3: data_o = 8'h2e; 8'hc4: data_o = 8'h1c; 8'hc5: data_o = 8'ha6; 8'hc6: data_o = 8'hb4; 8'hc7: data_o = 8'hc6;
            8'hc8: data_o = 8'he8; 8'hc9: data_o = 8'hdd; 8'hca: data_o = 8'h74; 8'hcb: data_o = 8'h1f; 8'hcc: data_o = 8'h4b; 8'hcd: data_o = 8'hbd; 8'hce: data_o = 8'h8b; 8'hcf: data_o = 8'h8a;
            8'hd0: data_o = 8'h70; 8'hd1: data_o = 8'h3e; 8'hd2: data_o = 8'hb5; 8'hd3: data_o = 8'h66; 8'hd4: data_o = 8'h48; 8'hd5: data_o = 8'h03; 8'hd6: data_o = 8'hf6; 8'hd7: data_o = 8'h0e;
            8'hd8: data_o = 8'h61; 8'hd9: data_o = 8'h35; 8'hda: data_o = 8'h57; 8'hdb: data_o = 8'hb9; 8'hdc: data_o = 8'h86; 8'hdd: data_o = 8'hc1; 8'hde: data_o = 8'h1d; 8'hdf: data_o = 8'h9e;
            8'he0: data_o = 8'he1; 8'he1: data_o = 8'hf8; 8'he2: data_o = 8'h98; 8'he3: data_o = 8'h11; 8'he4: data_o = 8'h69; 8'he5: data_o = 8'hd9; 8'he6: data_o = 8'h8e; 8'he7: data_o = 8'h94;
            8'he8: data_o = 8'h9b; 8'he9: data_o = 8'h1e; 8'hea: data_o = 8'h87; 8'heb: data_o = 8'he9; 8'hec: data_o = 8'hce; 8'hed: data_o = 8'h55; 8'hee: data_o = 8'h28; 8'hef: data_o = 8'hdf;
            8'hf0: data_o = 8'h8c; 8'hf1: data_o = 8'ha1; 8'hf2: data_o = 8'h89; 8'hf3: data_o = 8'h0d; 8'hf4: data_o = 8'hbf; 8'hf5: data_o = 8'he6; 8'hf6: data_o = 8'h42; 8'hf7: data_o = 8'h68;
            8'hf8: data_o = 8'h41; 8'hf9: data_o = 8'h99; 8'hfa: data_o = 8'h2d; 8'hfb: data_o = 8'h0f; 8'hfc: data_o = 8'hb0; 8'hfd: data_o = 8'h54; 8'hfe: data_o = 8'hbb; 8'hff: data_o = 8'h16;
            default: data_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: iterative AES-128 key schedule, one round key per output handshake.
// Optional feature macro AES_KEY_EXPAND_REPLAY_EN adds rk_replay and an 11-entry round-key store.
module aes_key_expand_seq
    import aes_ks_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [RK_W-1:0]  key_in,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [RK_W-1:0]  rk_data,
    output logic [IDX_W-1:0] rk_index,
    output logic             busy
`ifdef AES_KEY_EXPAND_REPLAY_EN
    ,
    input  logic             rk_replay
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [RK_W-1:0]   rk_data_q, rk_data_d;
    logic [IDX_W-1:0]  rk_index_q, rk_index_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              key_ready_q, key_ready_d;
    logic              rk_valid_q, rk_valid_d;
    logic              busy_q, busy_d;

    logic [WORD_W-1:0] w0_c, w1_c, w2_c, w3_c;
    logic [WORD_W-1:0] rot_c, sub_c, t_c;
    logic [WORD_W-1:0] n0_c, n1_c, n2_c, n3_c;
    logic [7:0]        rcon_c;
    logic              hs_c;
    logic              last_c;

`ifdef AES_KEY_EXPAND_REPLAY_EN
    logic [RK_W-1:0]   store_q [NUM_RK];
    logic              stored_ok_q, stored_ok_d;
    logic              replay_q, replay_d;
    logic              store_we_c;
    logic [IDX_W-1:0]  idx_inc_c;
`endif

    // One schedule step: RotWord/SubWord/Rcon on w3, then the 4-deep XOR chain.
    assign w0_c   = rk_data_q[RK_W-1 -: WORD_W];
    assign w1_c   = rk_data_q[RK_W-1-WORD_W -: WORD_W];
    assign w2_c   = rk_data_q[RK_W-1-2*WORD_W -: WORD_W];
    assign w3_c   = rk_data_q[WORD_W-1:0];
    assign rot_c  = rot_word(w3_c);
    assign rcon_c = (ptr_q < IDX_W'(NUM_RCON)) ? RCON[ptr_q] : 8'h00;
    assign t_c    = xor_words(sub_c, {rcon_c, 24'h000000});
    assign n0_c   = xor_words(w0_c, t_c);
    assign n1_c   = xor_words(w1_c, n0_c);
    assign n2_c   = xor_words(w2_c, n1_c);
    assign n3_c   = xor_words(w3_c, n2_c);

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        aes_sbox u_sbox (
            .data_i (rot_c[8*gi +: 8]),
            .data_o (sub_c[8*gi +: 8])
        );
    end

    assign hs_c   = rk_valid_q && rk_ready;
    assign last_c = (rk_index_q == IDX_W'(LAST_IDX));

`ifdef AES_KEY_EXPAND_REPLAY_EN
    assign idx_inc_c  = rk_index_q + IDX_W'(1);
    assign store_we_c = (state_q == ST_EMIT) && hs_c && !replay_q;
`endif

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        state_d     = state_q;
        rk_data_d   = rk_data_q;
        rk_index_d  = rk_index_q;
        ptr_d       = ptr_q;
        key_ready_d = key_ready_q;
        rk_valid_d  = rk_valid_q;
        busy_d      = busy_q;
`ifdef AES_KEY_EXPAND_REPLAY_EN
        stored_ok_d = stored_ok_q;
        replay_d    = replay_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (key_valid && key_ready_q) begin
                    state_d     = ST_EMIT;
                    rk_data_d   = key_in;
                    rk_index_d  = '0;
                    ptr_d       = '0;
                    key_ready_d = 1'b0;
                    rk_valid_d  = 1'b1;
                    busy_d      = 1'b1;
`ifdef AES_KEY_EXPAND_REPLAY_EN
                    stored_ok_d = 1'b0;
                    replay_d    = 1'b0;
                end else if (rk_replay && stored_ok_q) begin
                    state_d     = ST_EMIT;
                    rk_data_d   = store_q[0];
                    rk_index_d  = '0;
                    ptr_d       = '0;
                    key_ready_d = 1'b0;
                    rk_valid_d  = 1'b1;
                    busy_d      = 1'b1;
                    replay_d    = 1'b1;
`endif
                end
            end
            ST_EMIT: begin
                if (hs_c) begin
                    if (last_c) begin
                        state_d     = ST_IDLE;
                        key_ready_d = 1'b1;
                        rk_valid_d  = 1'b0;
                        busy_d      = 1'b0;
`ifdef AES_KEY_EXPAND_REPLAY_EN
                        stored_ok_d = 1'b1;
                        replay_d    = 1'b0;
`endif
                    end else begin
`ifdef AES_KEY_EXPAND_REPLAY_EN
                        rk_data_d = replay_q ? store_q[idx_inc_c] : {n0_c, n1_c, n2_c, n3_c};
`else
                        rk_data_d = {n0_c, n1_c, n2_c, n3_c};
`endif
                        rk_index_d = rk_index_q + IDX_W'(1);
                        ptr_d      = ptr_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and round-key registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rk_data_q   <= '0;
            rk_index_q  <= '0;
            ptr_q       <= '0;
            key_ready_q <= 1'b1;
            rk_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef AES_KEY_EXPAND_REPLAY_EN
            stored_ok_q <= 1'b0;
            replay_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rk_data_q   <= rk_data_d;
            rk_index_q  <= rk_index_d;
            ptr_q       <= ptr_d;
            key_ready_q <= key_ready_d;
            rk_valid_q  <= rk_valid_d;
            busy_q      <= busy_d;
`ifdef AES_KEY_EXPAND_REPLAY_EN
            stored_ok_q <= stored_ok_d;
            replay_q    <= replay_d;
`endif
        end
    end

`ifdef AES_KEY_EXPAND_REPLAY_EN
    // Round-key store: slot n captures RKn as it is handed off; validity lives in stored_ok_q.
    always_ff @(posedge clk) begin
        if (store_we_c) begin
            store_q[rk_index_q] <= rk_data_q;
        end
    end
`endif

    assign key_ready = key_ready_q;
    assign rk_valid  = rk_valid_q;
    assign rk_data   = rk_data_q;
    assign rk_index  = rk_index_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench for aes_key_expand_seq against a GF(2^8)-derived key-schedule model.
module tb_aes_key_expand_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         busy;
`ifdef AES_KEY_EXPAND_REPLAY_EN
    logic         rk_replay;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] exp_rk [11];
    logic [127:0] got_rk [11];

    localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_RK1   = 128'h62636363626363636263636362636363;

    aes_key_expand_seq dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_data   (rk_data),
        .rk_index  (rk_index),
        .busy      (busy)
`ifdef AES_KEY_EXPAND_REPLAY_EN
        ,
        .rk_replay (rk_replay)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    // Textbook 44-word expansion; round key n is words 4n..4n+3.
    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int n = 0; n < 11; n++) exp_rk[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_key_ready(input string tag);
        int budget;
        budget = 0;
        while (key_ready !== 1'b1 && budget < 40) begin
            @(posedge clk); #1;
            budget++;
        end
        chk(tag, 128'(key_ready), 128'(1));
    endtask

    // mode 0: start by key, 1: start by replay, 2: key and replay together.
    task automatic run_sched(input int mode, input logic [127:0] key, input int stall_at,
                             input int stall_len, input bit junk_kv);
        if (mode != 1) expand(key);
        wait_key_ready("key_ready_before_start");
        key_valid = (mode != 1);
        key_in    = key;
`ifdef AES_KEY_EXPAND_REPLAY_EN
        rk_replay = (mode != 0);
`endif
        @(posedge clk); #1;
        key_valid = 1'b0;
`ifdef AES_KEY_EXPAND_REPLAY_EN
        rk_replay = 1'b0;
`endif
        chk("start_key_ready", 128'(key_ready), 128'(0));
        chk("start_busy", 128'(busy), 128'(1));
        for (int n = 0; n < 11; n++) begin
            chk($sformatf("rk_data[%0d]", n), rk_data, exp_rk[n]);
            chk($sformatf("rk_index[%0d]", n), 128'(rk_index), 128'(n));
            chk($sformatf("rk_valid[%0d]", n), 128'(rk_valid), 128'(1));
            got_rk[n] = rk_data;
            if (n == stall_at) begin
                rk_ready = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    @(posedge clk); #1;
                    chk($sformatf("stall_data[%0d]", n), rk_data, exp_rk[n]);
                    chk($sformatf("stall_index[%0d]", n), 128'(rk_index), 128'(n));
                    chk($sformatf("stall_valid[%0d]", n), 128'(rk_valid), 128'(1));
                end
            end
            rk_ready = 1'b1;
            if (junk_kv) begin
                key_valid = 1'b1;
                key_in    = rnd128();
            end
            @(posedge clk); #1;
            key_valid = 1'b0;
            rk_ready  = 1'b0;
        end
        chk("end_key_ready", 128'(key_ready), 128'(1));
        chk("end_rk_valid", 128'(rk_valid), 128'(0));
        chk("end_busy", 128'(busy), 128'(0));
        chk("end_rk_data_hold", rk_data, exp_rk[10]);
        chk("end_rk_index_hold", 128'(rk_index), 128'(10));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_key_ready"}, 128'(key_ready), 128'(1));
        chk({tag, "_rk_valid"}, 128'(rk_valid), 128'(0));
        chk({tag, "_rk_data"}, rk_data, 128'(0));
        chk({tag, "_rk_index"}, 128'(rk_index), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
    endtask

    initial begin
        int budget;
        int sa;
        rst       = 1'b1;
        key_valid = 1'b0;
        key_in    = '0;
        rk_ready  = 1'b0;
`ifdef AES_KEY_EXPAND_REPLAY_EN
        rk_replay = 1'b0;
`endif
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Reference vector, unstalled, then with backpressure at RK3.
        run_sched(0, KEY_A1, -1, 0, 1'b0);
        chk("a1_rk0", got_rk[0], KEY_A1);
        chk("a1_rk1", got_rk[1], A1_RK1);
        chk("a1_rk10", got_rk[10], A1_RK10);
        run_sched(0, KEY_A1, 3, 5, 1'b0);
        chk("a1_stall_rk10", got_rk[10], A1_RK10);

        // Key offers during the schedule must be ignored.
        run_sched(0, KEY_A1, -1, 0, 1'b1);
        chk("a1_junk_rk10", got_rk[10], A1_RK10);

        run_sched(0, 128'(0), -1, 0, 1'b0);
        chk("zero_rk1", got_rk[1], Z_RK1);

        for (int r = 0; r < 6; r++) begin
            sa = int'($urandom_range(0, 10));
            run_sched(0, rnd128(), sa, int'($urandom_range(1, 4)), 1'(r % 2));
        end

        // Asynchronous reset in the middle of a schedule.
        wait_key_ready("mid_rst_key_ready");
        key_valid = 1'b1;
        key_in    = rnd128();
        rk_ready  = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        budget = 0;
        while (rk_index !== 4'd6 && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("mid_rst_reach_idx6", 128'(rk_index), 128'(6));
        rst      = 1'b1;
        rk_ready = 1'b0;
        #1;
        check_reset_outputs("mid_rst_now");
        @(posedge clk); #1;
        check_reset_outputs("mid_rst_next");
        rst = 1'b0;
        @(posedge clk); #1;

`ifdef AES_KEY_EXPAND_REPLAY_EN
        // Store was invalidated by reset: replay request must be ignored.
        rk_replay = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rk_replay = 1'b0;
        chk("replay_ignored_valid", 128'(rk_valid), 128'(0));
        chk("replay_ignored_busy", 128'(busy), 128'(0));
        chk("replay_ignored_ready", 128'(key_ready), 128'(1));

        run_sched(0, KEY_A1, -1, 0, 1'b0);
        run_sched(1, KEY_A1, 2, 3, 1'b0);
        chk("replay_rk10", got_rk[10], A1_RK10);
        run_sched(2, rnd128(), -1, 0, 1'b0);
        run_sched(1, 128'(0), 7, 2, 1'b0);
`else
        run_sched(0, rnd128(), -1, 0, 1'b0);
`endif
        run_sched(0, KEY_A1, -1, 0, 1'b0);
        chk("final_rk1", got_rk[1], A1_RK1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_key_expand_seq.md
# aes_key_expand_seq

Iterative AES-128 key-expansion sequencer. Accepts one 128-bit cipher key and emits the 11 round keys (RK0..RK10) one at a time over a valid/ready stream. It sits directly upstream of the AES round datapath cones and supplies the round-key operand consumed by each AddRoundKey cone. One round key is computed per accepted output handshake, using four S-box lookups per step.

## Interface
- NUM_RK, default 11, number of round keys emitted; fixed for AES-128, with no other legal value.
- clk  in  1  sole clock; all flops rising-edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  cipher key offered.
- key_ready  out  1  sequencer can accept a key.
- key_in  in  128  cipher key; bits [127:120] are byte 0.
- rk_valid  out  1  round key on rk_data is valid.
- rk_ready  in  1  consumer accepts the round key.
- rk_data  out  128  current round key, same byte order as key_in.
- rk_index  out  4  index of rk_data, 0..10.
- busy  out  1  a schedule is in progress.
- rk_replay  in  1  present only with AES_KEY_EXPAND_REPLAY_EN.

## Operation
- States:
  - IDLE: key_ready=1, rk_valid=0, busy=0.
  - EMIT: rk_valid=1, busy=1.
- Reset values: state IDLE, key_ready 1, rk_valid 0, rk_data 0, rk_index 0, busy 0.
- IDLE -> EMIT on key_valid && key_ready.
  - rk_data <= key_in.
  - rk_index <= 0.
  - Rcon pointer <= 0.
- EMIT with rk_valid && rk_ready and rk_index < 10:
  - Split rk_data into words w0..w3, with w0 at bits [127:96].
  - t = SubWord(RotWord(w3)) ^ {RCON[ptr], 24'h0}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - rk_data <= {n0,n1,n2,n3}.
  - rk_index and ptr each increment by 1.
- EMIT with a handshake at rk_index == 10 -> IDLE. rk_data and rk_index hold their last values.
- EMIT without a handshake: rk_data and rk_index hold stable. rk_valid never drops until the handshake completes.
- RCON sequence: 01,02,04,08,10,20,40,80,1b,36.
- All XORs are 8-bit bytewise with no carries. RotWord rotates bytes left by one: {b1,b2,b3,b0}.
- key_valid is ignored outside IDLE. A new key is never accepted in the same cycle as the RK10 handshake.

## Timing
- Key acceptance to RK0 valid: 1 cycle, registered.
- RK(n) handshake to RK(n+1) valid: 1 cycle. Back-to-back with rk_ready held high, RK0..RK10 occupy 11 consecutive cycles.
- RK10 handshake: key_ready is 1 on the next cycle, so the minimum key-to-key interval is 12 cycles.
- key_ready and rk_valid are decoded from registered state only. There is no combinational path from rk_ready or key_valid to any output.
- rst asserted mid-schedule: all outputs return to reset values immediately. The schedule is abandoned, and with the macro, the stored schedule is invalidated.
- Critical path: rk_data register -> S-box -> 4-stage XOR chain -> rk_data register.

## Configuration
- AES_KEY_EXPAND_REPLAY_EN defined:
  - Adds the rk_replay input and an 11x128 round-key store plus a stored_ok flag.
  - Each emitted RKn is written to the store at slot n. stored_ok is set on the RK10 handshake.
  - rk_replay in IDLE with stored_ok=1 enters EMIT, driving rk_data from the store. Indices and timing are identical, with no S-box use.
  - rk_replay with stored_ok=0 is ignored.
  - key_valid and rk_replay together in IDLE: key_valid wins. The key is accepted, stored_ok clears, and the store is overwritten.
- AES_KEY_EXPAND_REPLAY_EN undefined: no rk_replay port, no store, no stored_ok.

## Structure
- Package aes_ks_pkg holds:
  - state enum {IDLE, EMIT};
  - NUM_RK = 11;
  - RK_W = 128, IDX_W = 4;
  - the RCON[0:9] byte array;
  - functions rot_word and xor_words.
- Sub-module aes_sbox: purely combinational 8-bit -> 8-bit forward S-box as a 256-entry case. It is instantiated 4 times, once per byte of RotWord(w3).

## Test plan
- FIPS-197 A.1: key_in=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> RK0 equals key. RK1=a0fafe1788542cb123a339392a6c7605. RK10=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_index=10. key_ready returns on the next cycle.
- Backpressure: rk_ready low for 5 cycles at rk_index=3 -> rk_data and rk_index stable and rk_valid held at 1. Completion then yields the same RK10 as an unstalled run.
- key_valid pulses during EMIT -> ignored, with no change to the sequence.
- Key of all zeros -> RK1=62636363626363636263636362636363.
- rst asserted at rk_index=6 -> next cycle key_ready=1, rk_valid=0, rk_data=0, busy=0. A new key then restarts from RK0.
- REPLAY_EN build: finish the A.1 key, then pulse rk_replay -> the identical 11 round keys are emitted. rk_replay right after reset is ignored. key_valid together with rk_replay accepts the new key.
